// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, programmable terminal value
// and a registered terminal-count flag. Wraps or saturates via SATURATE.
module bcd_updown_counter #(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc
);

    // Digit-wise views; index 0 is the least-significant digit.
    logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0] lim, ld, inc, dec;
    logic                   tc_q, tc_d;

    // Sanitise inputs: limit digits above 9 act as 9, bad load digits become 0.
    always_comb begin
        lim = '0;
        ld  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            lim[i] = (limit[4*i +: 4]    > 4'd9) ? 4'd9 : limit[4*i +: 4];
            ld[i]  = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    end

    // Ripple BCD increment and decrement across all digits in one cycle.
    always_comb begin
        logic cy;
        logic bw;
        inc = cnt_q;
        dec = cnt_q;
        cy  = 1'b1;
        bw  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (cnt_q[i] == 4'd9) begin
                    inc[i] = 4'd0;
                end else begin
                    inc[i] = cnt_q[i] + 4'd1;
                    cy     = 1'b0;
                end
            end
            if (bw) begin
                if (cnt_q[i] == 4'd0) begin
                    dec[i] = 4'd9;
                end else begin
                    dec[i] = cnt_q[i] - 4'd1;
                    bw     = 1'b0;
                end
            end
        end
    end

    // Next-state: load beats count; digits are always valid BCD here, so a
    // plain packed-vector compare is the numeric BCD magnitude compare.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load) begin
            cnt_d = ld;
        end else if (en) begin
            if (up) begin
                if (cnt_q >= lim) begin
                    cnt_d = SATURATE ? lim : '0;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = inc;
                    // In hold mode, arriving at the limit is already terminal.
                    if (SATURATE && (inc == lim)) tc_d = 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = SATURATE ? '0 : lim;
                    tc_d  = 1'b1;
                end else if (cnt_q > lim) begin
                    cnt_d = lim;
                end else begin
                    cnt_d = dec;
                end
            end
        end
    end

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign count = cnt_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: wrapping and saturating 2-digit counters plus a 4-digit one.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [7:0]  load_val, limit;
    logic [15:0] load_val2, limit2;
    logic [7:0]  count0, count1;
    logic [15:0] count2;
    logic        tc0, tc1, tc2;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .limit(limit), .count(count0), .tc(tc0));
    bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .limit(limit), .count(count1), .tc(tc1));
    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val2), .limit(limit2), .count(count2), .tc(tc2));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0;
        load_val = '0; limit = '0; load_val2 = '0; limit2 = '0;
        #2;
        chk("rst_cnt", count0, 8'h00);
        chk("rst_tc",  tc0,    1'b0);
        chk("rst_cnt2", count2, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        limit = 8'h59; en = 1'b1; up = 1'b1;
        rst = 1'b0;

        // Full wrapping up-count 00..59 then back to 00.
        for (int k = 1; k <= 60; k++) begin
            step();
            chk($sformatf("up_cnt%0d", k), count0, (k == 60) ? 8'h00 : bcd2(k));
            chk($sformatf("up_tc%0d", k),  tc0,    (k == 60) ? 1'b1 : 1'b0);
        end
        step();
        chk("post_wrap_cnt", count0, 8'h01);
        chk("post_wrap_tc",  tc0,    1'b0);

        // Load with an invalid low digit, then count down.
        en = 1'b0; load = 1'b1; load_val = 8'h3C;
        step();
        chk("ld3C_cnt", count0, 8'h30);
        chk("ld3C_tc",  tc0,    1'b0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step(); chk("dn29", count0, 8'h29);
        step(); chk("dn28", count0, 8'h28);

        // Down wrap from zero, then down from above the limit.
        en = 1'b0; load = 1'b1; load_val = 8'h00;
        step(); chk("ld00", count0, 8'h00);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("dnwrap_cnt", count0, 8'h59);
        chk("dnwrap_tc",  tc0,    1'b1);
        en = 1'b0; load = 1'b1; load_val = 8'h75;
        step(); chk("ld75", count0, 8'h75);
        load = 1'b0; en = 1'b1;
        step();
        chk("dnclip_cnt", count0, 8'h59);
        chk("dnclip_tc",  tc0,    1'b0);
        step(); chk("dn58", count0, 8'h58);

        // Limit 12: saturating holds with tc, wrapping returns to 00.
        limit = 8'h12; en = 1'b0; load = 1'b1; load_val = 8'h11;
        step(); chk("ld11_sat", count1, 8'h11);
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("sat12a_cnt", count1, 8'h12); chk("sat12a_tc", tc1, 1'b1);
        chk("wrp12_cnt",  count0, 8'h12); chk("wrp12_tc",  tc0, 1'b0);
        step();
        chk("sat12b_cnt", count1, 8'h12); chk("sat12b_tc", tc1, 1'b1);
        chk("wrp00_cnt",  count0, 8'h00); chk("wrp00_tc",  tc0, 1'b1);
        step();
        chk("sat12c_cnt", count1, 8'h12); chk("sat12c_tc", tc1, 1'b1);
        chk("wrp01_cnt",  count0, 8'h01); chk("wrp01_tc",  tc0, 1'b0);
        en = 1'b0;
        step();
        chk("satidle_cnt", count1, 8'h12); chk("satidle_tc", tc1, 1'b0);
        chk("idle_cnt", count0, 8'h01);

        // Limit of zero.
        limit = 8'h00; en = 1'b1; up = 1'b1;
        step(); chk("lim0a_cnt", count0, 8'h00); chk("lim0a_tc", tc0, 1'b1);
        step(); chk("lim0b_cnt", count0, 8'h00); chk("lim0b_tc", tc0, 1'b1);

        // Limit digit above 9 acts as 9.
        limit = 8'h5F; en = 1'b0; load = 1'b1; load_val = 8'h58;
        step(); chk("ld58", count0, 8'h58);
        load = 1'b0; en = 1'b1; up = 1'b1;
        step(); chk("clamp59_cnt", count0, 8'h59); chk("clamp59_tc", tc0, 1'b0);
        step(); chk("clamp00_cnt", count0, 8'h00); chk("clamp00_tc", tc0, 1'b1);

        // Direction flips take effect on the same step.
        up = 1'b0;
        step(); chk("flipdn_cnt", count0, 8'h59); chk("flipdn_tc", tc0, 1'b1);
        up = 1'b1;
        step(); chk("flipup_cnt", count0, 8'h00); chk("flipup_tc", tc0, 1'b1);

        // Load wins over enable.
        load = 1'b1; load_val = 8'h42;
        step(); chk("ldwin_cnt", count0, 8'h42); chk("ldwin_tc", tc0, 1'b0);

        // Asynchronous reset between clock edges.
        en = 1'b0; load_val = 8'h37;
        step(); chk("ld37", count0, 8'h37);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt0", count0, 8'h00);
        chk("arst_tc0",  tc0,    1'b0);
        chk("arst_cnt1", count1, 8'h00);
        #1 rst = 1'b0;
        en = 1'b1; up = 1'b1;
        step(); chk("postrst_cnt", count0, 8'h01); chk("postrst_tc", tc0, 1'b0);

        // Four digits: carry and borrow across three digits.
        en = 1'b0; load = 1'b1; load_val2 = 16'h0999; limit2 = 16'h9999;
        step(); chk("ld0999", count2, 16'h0999);
        load = 1'b0; en = 1'b1; up = 1'b1;
        step(); chk("c1000_cnt", count2, 16'h1000); chk("c1000_tc", tc2, 1'b0);
        up = 1'b0;
        step(); chk("b0999_cnt", count2, 16'h0999); chk("b0999_tc", tc2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
